// File: rtl/pdp8_bus_pkg.sv
// pdp8_bus_pkg: shared register-bus constants and transfer sequencer states
package pdp8_bus_pkg;
  localparam int NREG = 8;
  localparam int W = 12;
  typedef enum logic [1:0] {IDLE, DRIVE, COMMIT, DONE} state_t;
endpackage

// File: rtl/dec3to8.sv
// dec3to8: enabled 3-to-8 one-hot decoder
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);
  assign y = en ? 8'b1 << sel : 8'b0;
endmodule

// File: rtl/xfer_seq.sv
// xfer_seq: sequences one register-to-register bus transfer (drive, commit, done)
module xfer_seq
  import pdp8_bus_pkg::*;
#(
  parameter int NREG = pdp8_bus_pkg::NREG,
  parameter int W = pdp8_bus_pkg::W
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            req,
  input  logic            clr,
  input  logic [2:0]      src,
  input  logic [2:0]      dst,
  input  logic [W-1:0]    bus_in,
  output logic            ready,
  output logic            ack,
  output logic [NREG-1:0] oe,
  output logic [NREG-1:0] hold,
  output logic [NREG-1:0] latch,
  output logic [W-1:0]    snap
);
  state_t state_q, state_d;
  logic [2:0] src_q, src_d, dst_q, dst_d;
  logic clr_q, clr_d;
  logic [W-1:0] snap_q, snap_d;
  logic [NREG-1:0] hold_n;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      clr_q <= 1'b0;
      snap_q <= '0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      clr_q <= clr_d;
      snap_q <= snap_d;
    end
  end
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    clr_d = clr_q;
    snap_d = snap_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = DRIVE;
        src_d = src;
        dst_d = dst;
        clr_d = clr;
      end
      DRIVE: begin
        state_d = COMMIT;
        snap_d = clr_q ? '0 : bus_in;
      end
      COMMIT: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  assign ready = state_q == IDLE;
  assign ack = state_q == DONE;
  assign hold = ~hold_n;
  assign snap = snap_q;
  // a clear transfer opens the destination but drives nothing, so it loads zero
  dec3to8 u_oe (.en(state_q == DRIVE && !clr_q), .sel(src_q), .y(oe));
  dec3to8 u_hold (.en(state_q == DRIVE), .sel(dst_q), .y(hold_n));
  dec3to8 u_latch (.en(state_q == COMMIT), .sel(dst_q), .y(latch));
endmodule

// File: tb/tb_xfer_seq.sv
// tb_xfer_seq: scoreboard bench for xfer_seq driving eight MultiLatch-style registers
module tb_xfer_seq;
  import pdp8_bus_pkg::*;
  localparam int TW = 26;
  typedef struct packed {
    logic [2:0]   d;
    logic [W-1:0] val;
    logic [W-1:0] snap;
  } res_t;
  logic CLK = 0, RESET = 1, req = 0, clr = 0;
  logic [2:0] src = 0, dst = 0;
  logic [W-1:0] bus_in, snap;
  logic ready, ack;
  logic [NREG-1:0] oe, hold, latch;
  logic [W-1:0] r [NREG];
  logic [W-1:0] stage [NREG];
  logic pl_en = 0;
  logic [2:0] pl_idx = 0;
  logic [W-1:0] pl_val = 0;
  logic mon_en = 0;
  logic [TW-1:0] ctl_q [$];
  res_t res_q [$];
  int checks = 0, passes = 0;

  always #5 CLK = ~CLK;

  xfer_seq dut (
    .CLK(CLK), .RESET(RESET), .req(req), .clr(clr), .src(src), .dst(dst),
    .bus_in(bus_in), .ready(ready), .ack(ack), .oe(oe), .hold(hold),
    .latch(latch), .snap(snap)
  );

  always_comb begin
    bus_in = '0;
    for (int i = 0; i < NREG; i++) bus_in = bus_in | (oe[i] ? r[i] : '0);
  end

  // registers: holding stage follows the bus unless frozen, latch commits it
  always @(posedge CLK)
    for (int i = 0; i < NREG; i++)
      if (RESET) begin
        r[i] <= '0;
        stage[i] <= '0;
      end else if (pl_en && pl_idx == 3'(i)) r[i] <= pl_val;
      else begin
        if (!hold[i]) stage[i] <= bus_in;
        if (latch[i]) r[i] <= stage[i];
      end

  function automatic logic [TW-1:0] vec(logic rd, logic ak, logic [7:0] o, logic [7:0] h, logic [7:0] l);
    return {rd, ak, o, h, l};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  always @(negedge CLK) if (mon_en) begin : mon
    logic [TW-1:0] e;
    res_t p;
    e = ctl_q.size() != 0 ? ctl_q.pop_front() : vec(1'b1, 1'b0, 8'h00, 8'hFF, 8'h00);
    check("ctl {ready,ack,oe,hold,latch}", 32'({ready, ack, oe, hold, latch}), 32'(e));
    if (ack) begin
      if (res_q.size() == 0) check("spurious_ack", 32'(ack), 32'd0);
      else begin
        p = res_q.pop_front();
        check("snap", 32'(snap), 32'(p.snap));
        check("dst_reg", 32'(r[p.d]), 32'(p.val));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic xfer(input logic [2:0] s, input logic [2:0] d, input logic c, input logic [W-1:0] v, input bit keep);
    ctl_q.push_back(vec(1'b1, 1'b0, 8'h00, 8'hFF, 8'h00));
    ctl_q.push_back(vec(1'b0, 1'b0, c ? 8'h00 : 8'h01 << s, ~(8'h01 << d), 8'h00));
    ctl_q.push_back(vec(1'b0, 1'b0, 8'h00, 8'hFF, 8'h01 << d));
    ctl_q.push_back(vec(1'b0, 1'b1, 8'h00, 8'hFF, 8'h00));
    res_q.push_back('{d, v, v});
    req = 1;
    src = s;
    dst = d;
    clr = c;
    for (int k = 0; k < 4; k++) begin
      step();
      pl_en = 0;
      req = keep;
      src = keep ? s ^ 3'(k + 1) : 3'd0;
      dst = keep ? d ^ 3'(k + 2) : 3'd0;
      clr = keep ? ~k[0] : 1'b0;
    end
  endtask

  task automatic preload(input logic [2:0] i, input logic [W-1:0] v);
    pl_en = 1;
    pl_idx = i;
    pl_val = v;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    RESET = 1;
    step();
    mon_en = 1;
    step();
    RESET = 0;
    preload(3'd2, 12'o1234);
    xfer(3'd2, 3'd5, 1'b0, 12'o1234, 0);
    preload(3'd3, 12'o7777);
    xfer(3'd2, 3'd3, 1'b1, 12'o0000, 0);
    preload(3'd4, 12'o0505);
    xfer(3'd4, 3'd4, 1'b0, 12'o0505, 0);
    xfer(3'd5, 3'd1, 1'b0, 12'o1234, 1);
    xfer(3'd2, 3'd7, 1'b0, 12'o1234, 1);
    xfer(3'd7, 3'd0, 1'b0, 12'o1234, 1);
    req = 0;
    src = 0;
    dst = 0;
    clr = 0;
    step();
    ctl_q.push_back(vec(1'b1, 1'b0, 8'h00, 8'hFF, 8'h00));
    ctl_q.push_back(vec(1'b0, 1'b0, 8'h02, 8'hBF, 8'h00));
    ctl_q.push_back(vec(1'b0, 1'b0, 8'h00, 8'hFF, 8'h40));
    req = 1;
    src = 3'd1;
    dst = 3'd6;
    step();
    req = 0;
    step();
    RESET = 1;
    step();
    RESET = 0;
    step();
    step();
    RESET = 1;
    req = 1;
    src = 3'd0;
    dst = 3'd7;
    step();
    RESET = 0;
    req = 0;
    step();
    step();
    preload(3'd1, 12'o4321);
    xfer(3'd1, 3'd3, 1'b0, 12'o4321, 0);
    step();
    step();
    check("pending_results", 32'(res_q.size()), 32'd0);
    check("pending_ctl", 32'(ctl_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
